// File: rtl/msg_fifo_pkg.sv
// Shared constants for the message-aware byte FIFO: FSM encoding, counter
// width and storage entry width ({byte, last}).
package msg_fifo_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_RECV = 3'b010,
      S_DROP = 3'b100
   } state_t;

   localparam int CNT_W   = 16;
   localparam int ENTRY_W = 9;

endpackage

// File: rtl/msg_fifo_ram.sv
// Byte-plus-last-flag storage: synchronous write, asynchronous read so the
// FIFO head can fall through combinationally.
module msg_fifo_ram #(
   parameter int AW = 6,
   parameter int W  = 9
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/msg_byte_fifo.sv
// Message-aware elastic byte buffer: only whole messages become visible.
// Build option MSG_BYTE_FIFO_STATS_EN enables the drop/commit counters.
module msg_byte_fifo
   import msg_fifo_pkg::*;
#(
   parameter int AW = 6,
   parameter int DW = 8
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             in_begin_i,
   input  logic [DW-1:0]    in_byte_i,
   input  logic             in_byte_valid_i,
   input  logic             in_end_i,
   output logic [DW-1:0]    out_byte_o,
   output logic             out_last_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [AW:0]      level_o,
   output logic             drop_pulse_o,
   output logic [CNT_W-1:0] drop_cnt_o,
   output logic [CNT_W-1:0] msg_cnt_o
);

   localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};

   state_t               state, state_nx;
   logic [AW:0]          rp, wp, wp_tmp;
   logic [AW:0]          wp_nx, wp_tmp_nx;
   logic [DW-1:0]        sb, sb_nx;
   logic                 sb_full, sb_full_nx;
   logic                 pend, pend_nx;
   logic [AW-1:0]        pend_addr, pend_addr_nx;
   logic [ENTRY_W-1:0]   pend_data, pend_data_nx;
   logic                 we;
   logic [AW-1:0]        waddr;
   logic [ENTRY_W-1:0]   wdata, rdata;
   logic                 drop;
   logic                 ovf, have;
   logic [AW:0]          ptr;
   logic [DW-1:0]        cur;

   function automatic logic is_full(input logic [AW:0] p, input logic [AW:0] r);
      return (p - r) == DEPTH_V;
   endfunction

   always_comb begin
      state_nx     = state;
      wp_nx        = wp;
      wp_tmp_nx    = wp_tmp;
      sb_nx        = sb;
      sb_full_nx   = sb_full;
      pend_nx      = 1'b0;
      pend_addr_nx = pend_addr;
      pend_data_nx = pend_data;
      we           = 1'b0;
      waddr        = wp_tmp[AW-1:0];
      wdata        = {sb, 1'b0};
      drop         = 1'b0;
      ovf          = 1'b0;
      have         = sb_full;
      ptr          = wp_tmp;
      cur          = sb;
      // The second half of a byte+end commit lands one cycle late; the
      // FSM is always in IDLE then, so the write port is free.
      if (pend) begin
         we    = 1'b1;
         waddr = pend_addr;
         wdata = pend_data;
      end
      unique case (state)
         S_IDLE: begin
            if (in_begin_i) begin
               state_nx   = S_RECV;
               wp_tmp_nx  = wp;
               sb_full_nx = 1'b0;
            end
         end
         S_RECV: begin
            if (in_begin_i) begin
               wp_tmp_nx  = wp;
               sb_full_nx = 1'b0;
               drop       = 1'b1;
            end else begin
               if (in_byte_valid_i) begin
                  if (sb_full) begin
                     if (is_full(wp_tmp, rp)) begin
                        ovf = 1'b1;
                     end else begin
                        we    = 1'b1;
                        waddr = wp_tmp[AW-1:0];
                        wdata = {sb, 1'b0};
                        ptr   = wp_tmp + 1'b1;
                     end
                  end
                  have = 1'b1;
                  cur  = in_byte_i;
               end
               if (ovf) begin
                  drop       = 1'b1;
                  wp_tmp_nx  = wp;
                  sb_full_nx = 1'b0;
                  state_nx   = in_end_i ? S_IDLE : S_DROP;
               end else if (in_end_i) begin
                  state_nx   = S_IDLE;
                  sb_full_nx = 1'b0;
                  if (have) begin
                     if (is_full(ptr, rp)) begin
                        drop = 1'b1;
                     end else begin
                        wp_nx     = ptr + 1'b1;
                        wp_tmp_nx = ptr + 1'b1;
                        if (we) begin
                           pend_nx      = 1'b1;
                           pend_addr_nx = ptr[AW-1:0];
                           pend_data_nx = {cur, 1'b1};
                        end else begin
                           we    = 1'b1;
                           waddr = ptr[AW-1:0];
                           wdata = {cur, 1'b1};
                        end
                     end
                  end
               end else begin
                  wp_tmp_nx  = ptr;
                  sb_nx      = cur;
                  sb_full_nx = have;
               end
            end
         end
         S_DROP: begin
            if (in_begin_i) begin
               state_nx   = S_RECV;
               wp_tmp_nx  = wp;
               sb_full_nx = 1'b0;
            end else if (in_end_i) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state        <= S_IDLE;
         rp           <= '0;
         wp           <= '0;
         wp_tmp       <= '0;
         sb           <= '0;
         sb_full      <= 1'b0;
         pend         <= 1'b0;
         pend_addr    <= '0;
         pend_data    <= '0;
         drop_pulse_o <= 1'b0;
      end else begin
         state        <= state_nx;
         wp           <= wp_nx;
         wp_tmp       <= wp_tmp_nx;
         sb           <= sb_nx;
         sb_full      <= sb_full_nx;
         pend         <= pend_nx;
         pend_addr    <= pend_addr_nx;
         pend_data    <= pend_data_nx;
         drop_pulse_o <= drop;
         if (out_valid_o && out_ready_i) rp <= rp + 1'b1;
      end
   end

   msg_fifo_ram #(.AW(AW), .W(ENTRY_W)) u_ram (
      .clk   (clk),
      .we    (we & aresetn),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (rp[AW-1:0]),
      .rdata (rdata)
   );

   assign out_valid_o = (rp != wp);
   assign out_byte_o  = rdata[ENTRY_W-1:1];
   assign out_last_o  = out_valid_o & rdata[0];
   assign level_o     = wp - rp;

`ifdef MSG_BYTE_FIFO_STATS_EN
   logic [CNT_W-1:0] drop_cnt, msg_cnt;

   // A commit is the only thing that moves wp.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         drop_cnt <= '0;
         msg_cnt  <= '0;
      end else begin
         if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
         if (wp_nx != wp && msg_cnt != '1) msg_cnt <= msg_cnt + 1'b1;
      end
   end

   assign drop_cnt_o = drop_cnt;
   assign msg_cnt_o  = msg_cnt;
`else
   assign drop_cnt_o = '0;
   assign msg_cnt_o  = '0;
`endif

endmodule
